rep3_tx: RTL and testbench



---
 rtl/rep3_pkg.sv | 20 ++
 rtl/rep_counter.sv | 28 ++
 rtl/rep3_tx.sv | 128 ++++++++++++
 tb/tb_rep3_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rep3_pkg.sv
// Shared definitions for the triple-repetition line code: state encoding,
// line levels and default sizes.
package rep3_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_e;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    localparam int REP_DEF    = 3;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/rep_counter.sv
// Modulo-REP counter with synchronous clear; wrap_o flags the last copy of a
// symbol. Shared with the receiver for triplet alignment.
module rep_counter #(
    parameter int REP = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en_i,
    output logic [$clog2(REP)-1:0] cnt_o,
    output logic                   wrap_o
);
    localparam int CW = $clog2(REP);
    localparam logic [CW-1:0] LAST = CW'(REP - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = (cnt_q == LAST);

endmodule

// File: rtl/rep3_tx.sv
// Triple-repetition serial transmitter: start 0, data LSB first, stop 1, each
// symbol repeated REP times. REP3_TX_PARITY_EN adds an even-parity symbol.
module rep3_tx
    import rep3_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REP    = REP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(REP);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] REP_LAST = CW'(REP - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
`ifdef REP3_TX_PARITY_EN
    localparam state_e AFTER_DATA = PAR;
`else
    localparam state_e AFTER_DATA = STOP;
`endif

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [CW-1:0]     rep_cnt, cnt_nxt;
    logic              rep_wrap, accept, load, last_nxt;
    logic              tx_d, busy_d, done_d, ready_d;
`ifdef REP3_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    rep_counter #(.REP(REP)) u_rep_cnt (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_q != IDLE),
        .cnt_o  (rep_cnt),
        .wrap_o (rep_wrap)
    );

    assign accept  = in_valid & in_ready;
    // Counter position the outputs will reflect after this edge.
    assign cnt_nxt = (state_q == IDLE || rep_wrap) ? '0 : rep_cnt + 1'b1;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        load    = 1'b0;
        case (state_q)
            IDLE:  if (accept) load = 1'b1;
            START: if (rep_wrap) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA:  if (rep_wrap) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 1'b1;
                if (bit_q == BIT_LAST) state_d = AFTER_DATA;
            end
`ifdef REP3_TX_PARITY_EN
            PAR:   if (rep_wrap) state_d = STOP;
`endif
            STOP:  if (rep_wrap) begin
                if (accept) load = 1'b1;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = START;
            shift_d = in_data;
        end
    end

`ifdef REP3_TX_PARITY_EN
    assign par_d = load ? ^in_data : par_q;
`endif

    // Output decode from next-state values so every output leaves a flop.
    always_comb begin
        last_nxt = (state_d == STOP) && (cnt_nxt == REP_LAST);
        busy_d   = (state_d != IDLE);
        done_d   = last_nxt;
        ready_d  = (state_d == IDLE) || last_nxt;
        case (state_d)
            START:   tx_d = START_LVL;
            DATA:    tx_d = shift_d[0];
`ifdef REP3_TX_PARITY_EN
            PAR:     tx_d = par_d;
`endif
            STOP:    tx_d = STOP_LVL;
            default: tx_d = IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            tx_out   <= IDLE_LVL;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b1;
`ifdef REP3_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            tx_out   <= tx_d;
            busy     <= busy_d;
            done     <= done_d;
            in_ready <= ready_d;
`ifdef REP3_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_rep3_tx.sv
// Self-checking bench for rep3_tx: frame-level reference model plus literal
// waveform pins; honours REP3_TX_PARITY_EN.
module tb_rep3_tx;
    localparam int DATA_W = 8;
    localparam int REP    = 3;
`ifdef REP3_TX_PARITY_EN
    localparam int NSYM = DATA_W + 3;
`else
    localparam int NSYM = DATA_W + 2;
`endif
    localparam int FLEN = NSYM * REP;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready, tx_out, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: expanded bit list of the frame in flight.
    bit m_seq[$];
    int m_pos = 0;
    bit m_act = 1'b0;

    rep3_tx #(.DATA_W(DATA_W), .REP(REP)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx_out   (tx_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_last();
        return m_act && (m_pos == m_seq.size() - 1);
    endfunction

    function automatic bit m_ready();
        return !m_act || m_last();
    endfunction

    function automatic bit m_tx();
        return m_act ? m_seq[m_pos] : 1'b1;
    endfunction

    task automatic m_load(input logic [DATA_W-1:0] w);
        bit sym[$];
        sym.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) sym.push_back(w[i]);
`ifdef REP3_TX_PARITY_EN
        sym.push_back(^w);
`endif
        sym.push_back(1'b1);
        m_seq.delete();
        foreach (sym[i]) for (int r = 0; r < REP; r++) m_seq.push_back(sym[i]);
        m_pos = 0;
        m_act = 1'b1;
    endtask

    // One clock: drive inputs, advance model on the edge, compare at negedge.
    task automatic cycle(input logic rst, input logic v, input logic [DATA_W-1:0] d);
        bit acc;
        reset    = rst;
        in_valid = v;
        in_data  = d;
        acc = !rst && v && m_ready();
        @(posedge clk);
        if (rst) begin
            m_act = 1'b0;
        end else begin
            if (m_act) begin
                m_pos++;
                if (m_pos == m_seq.size()) m_act = 1'b0;
            end
            if (acc) m_load(d);
        end
        @(negedge clk);
        chk("tx_out", tx_out, m_tx());
        chk("busy", busy, m_act);
        chk("done", done, m_last());
        chk("in_ready", in_ready, m_ready());
    endtask

    // Send one word from idle and capture its waveform, first bit in MSB side.
    task automatic send(input logic [DATA_W-1:0] w, output logic [63:0] cap,
                        output int done_at, output int ready_at);
        cap = '0;
        done_at = -1;
        ready_at = -1;
        cycle(1'b0, 1'b1, w);
        for (int k = 1; k <= FLEN; k++) begin
            if (k > 1) cycle(1'b0, 1'b0, '0);
            cap = {cap[62:0], tx_out};
            if (done && done_at < 0) done_at = k;
            if (in_ready && ready_at < 0) ready_at = k;
        end
        cycle(1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [63:0] cap;
        int d_at, r_at, busy_cnt, done_cnt;

        @(posedge clk);
        @(negedge clk);
        cycle(1'b1, 1'b0, '0);

        // Idle after reset
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0);
        chk("idle_tx", tx_out, 1);
        chk("idle_ready", in_ready, 1);
        chk("idle_busy", busy, 0);

        // 0xA5 frame waveform
        send(8'hA5, cap, d_at, r_at);
`ifdef REP3_TX_PARITY_EN
        chk("a5_wave", cap[FLEN-1:0], 33'b000111000111000000111000111000111);
`else
        chk("a5_wave", cap[FLEN-1:0], 30'b000111000111000000111000111111);
`endif
        chk("a5_done_cycle", d_at, FLEN);
        chk("a5_ready_cycle", r_at, FLEN);

        send(8'h01, cap, d_at, r_at);
`ifdef REP3_TX_PARITY_EN
        chk("01_wave", cap[FLEN-1:0], 33'b000111000000000000000000000111111);
`else
        chk("01_wave", cap[FLEN-1:0], 30'b000111000000000000000000000111);
`endif

        // Back-to-back 0x3C then 0xFF with in_valid held
        busy_cnt = 0;
        cycle(1'b0, 1'b1, 8'h3C);
        if (busy) busy_cnt++;
        for (int i = 0; i < FLEN; i++) begin
            cycle(1'b0, 1'b1, 8'hFF);
            if (busy) busy_cnt++;
        end
        chk("b2b_second_start", tx_out, 0);
        for (int i = 0; i < FLEN + 4; i++) begin
            cycle(1'b0, 1'b0, '0);
            if (busy) busy_cnt++;
        end
        chk("b2b_busy_cycles", busy_cnt, 2 * FLEN);

        // Mid-frame in_valid is ignored
        cycle(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 9; i++)  cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < FLEN; i++) cycle(1'b0, 1'b0, '0);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, '0);
            if (busy) busy_cnt++;
        end
        chk("ignored_no_extra", busy_cnt, 0);

        // Reset at cycle 12 of a 0xA5 frame, with a competing handshake
        done_cnt = 0;
        cycle(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 11; i++) begin
            cycle(1'b0, 1'b0, '0);
            if (done) done_cnt++;
        end
        cycle(1'b1, 1'b1, 8'hA5);
        chk("rst_tx", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_done", done_cnt + int'(done), 0);
        // Reset with handshake in idle: word must not be taken
        cycle(1'b1, 1'b1, 8'h55);
        cycle(1'b0, 1'b0, '0);
        chk("rst_wins_busy", busy, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                  DATA_W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
